// File: rtl/main_memory_burst.sv
// main_memory_burst: parametrised main-memory model behind L2.
// Accepts one line request, waits LATENCY cycles, then streams BURST
// beats (optionally critical-word-first, wrapping inside the line).
module main_memory_burst #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int MEM_AW  = 12,
  parameter int BURST   = 4,
  parameter int LATENCY = 3,
  parameter int WRAP    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_stb,
  output logic              o_last,
  output logic              o_busy
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int LAT_W   = $clog2(LATENCY + 1);
  localparam int BEAT_W  = $clog2(BURST) + 1;
  localparam int DEPTH   = 1 << MEM_AW;

  localparam logic [MEM_AW-1:0] LINE_MASK = MEM_AW'(BURST - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
  localparam logic [BEAT_W-1:0] BEAT_PEN  = BEAT_W'(BURST - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        r_state;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [BEAT_W-1:0] r_beat;
  logic              r_we;
  logic [MEM_AW-1:0] r_base;
  logic [MEM_AW-1:0] r_off;
  logic              r_stb;
  logic              r_last;
  logic              r_busy;
  logic [DATA_W-1:0] r_rdata;

  logic [MEM_AW-1:0] w_word;
  logic [MEM_AW-1:0] w_base_in;
  logic [MEM_AW-1:0] w_off_in;
  logic [MEM_AW-1:0] w_cur_idx;
  logic [MEM_AW-1:0] w_nxt_idx;
  logic              w_final;
  logic              w_accept;

  // Address decode, per-beat word index and accept qualification
  always_comb begin
    w_word    = MEM_AW'(i_addr >> BYTE_SH);
    w_base_in = w_word & ~LINE_MASK;
    w_off_in  = (WRAP != 0) ? (w_word & LINE_MASK) : '0;
    w_cur_idx = r_base | ((r_off + MEM_AW'(r_beat)) & LINE_MASK);
    w_nxt_idx = r_base | ((r_off + MEM_AW'(r_beat) + MEM_AW'(1)) & LINE_MASK);
    w_final   = (r_state == S_XFER) && (r_beat == BEAT_LAST);
    // a request held through the final beat is taken on the edge that ends it
    w_accept  = i_req && ((r_state == S_IDLE) || w_final);
  end

  // Burst sequencing: latency countdown, beat stepping, registered read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_beat    <= '0;
      r_we      <= 1'b0;
      r_base    <= '0;
      r_off     <= '0;
      r_stb     <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
        end
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_state <= S_XFER;
            r_beat  <= '0;
            r_stb   <= 1'b1;
            r_last  <= (BURST == 1);
            if (!r_we) begin
              r_rdata <= r_mem[r_base | r_off];
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        S_XFER: begin
          if (w_final) begin
            r_state <= S_IDLE;
            r_stb   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_beat <= r_beat + BEAT_W'(1);
            r_last <= (r_beat == BEAT_PEN);
            if (!r_we) begin
              r_rdata <= r_mem[w_nxt_idx];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_stb   <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
      // accept overrides the end-of-burst return to idle
      if (w_accept) begin
        r_we      <= i_we;
        r_base    <= w_base_in;
        r_off     <= w_off_in;
        r_lat_cnt <= LAT_W'(LATENCY - 1);
        r_busy    <= 1'b1;
        r_state   <= S_WAIT;
      end
    end
  end

  // Storage write: one word per strobed beat of a write-back burst, never reset
  always_ff @(posedge i_clk) begin
    if (r_stb && r_we) begin
      r_mem[w_cur_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;
  assign o_stb   = r_stb;
  assign o_last  = r_last;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_main_memory_burst.sv
// Testbench for main_memory_burst: scoreboard-checked default instance plus
// directed checks on a 32-bit/8-beat/latency-1 instance and a single-beat instance.
module tb_main_memory_burst;

  localparam int A_LAT   = 3;
  localparam int A_BURST = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  // default instance
  logic        a_req, a_we;
  logic [31:0] a_addr;
  logic [63:0] a_wdata, a_rdata;
  logic        a_stb, a_last, a_busy;

  // DATA_W=32, BURST=8, LATENCY=1, WRAP=1
  logic        b_req, b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        b_stb, b_last, b_busy;

  // BURST=1, LATENCY=2, WRAP=0
  logic        c_req, c_we;
  logic [31:0] c_addr;
  logic [63:0] c_wdata, c_rdata;
  logic        c_stb, c_last, c_busy;

  main_memory_burst u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(a_req), .i_we(a_we), .i_addr(a_addr),
    .i_wdata(a_wdata), .o_rdata(a_rdata), .o_stb(a_stb), .o_last(a_last), .o_busy(a_busy)
  );

  main_memory_burst #(.DATA_W(32), .BURST(8), .LATENCY(1), .WRAP(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .i_we(b_we), .i_addr(b_addr),
    .i_wdata(b_wdata), .o_rdata(b_rdata), .o_stb(b_stb), .o_last(b_last), .o_busy(b_busy)
  );

  main_memory_burst #(.BURST(1), .LATENCY(2), .WRAP(0)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(c_req), .i_we(c_we), .i_addr(c_addr),
    .i_wdata(c_wdata), .o_rdata(c_rdata), .o_stb(c_stb), .o_last(c_last), .o_busy(c_busy)
  );

  typedef struct {
    bit          wr;
    logic [63:0] data;
    int unsigned idx;
    int          cyc;
    bit          last;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ref_mem [int unsigned];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe of the default instance is matched to the oldest expected beat
  always @(negedge clk) begin : mon
    exp_t e;
    if (a_stb === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_stb", 64'(a_stb), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("stb_cycle", 64'(cyc), 64'(e.cyc));
        chk("last", 64'(a_last), 64'(e.last));
        if (e.wr) ref_mem[e.idx] = e.data;
        else      chk("rdata", a_rdata, e.data);
      end
    end else if (a_last === 1'b1) begin
      chk("last_without_stb", 64'(a_last), 64'(0));
    end
  end

  // L2-side write data: present the current beat's data as soon as its strobe rises
  always @(posedge clk) begin
    #1;
    if (a_stb === 1'b1 && sb_q.size() > 0 && sb_q[0].wr) a_wdata = sb_q[0].data;
  end

  // Reference model: line base / wrap offset from plain word arithmetic
  task automatic push_burst(input bit we, input logic [31:0] addr, input int t0,
                            input logic [63:0] base_val, input bit rnd);
    int unsigned w, base, o;
    exp_t e;
    w    = (addr / 8) % 4096;
    base = w - (w % A_BURST);
    o    = w % A_BURST;
    for (int i = 0; i < A_BURST; i++) begin
      e.wr   = we;
      e.idx  = base + ((o + i) % A_BURST);
      e.cyc  = t0 + A_LAT + i;
      e.last = (i == A_BURST - 1);
      if (we) e.data = rnd ? {$urandom, $urandom} : base_val + 64'(i);
      else    e.data = ref_mem.exists(e.idx) ? ref_mem[e.idx] : 64'hDEAD_0000_0000_0000;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'(a_busy), 64'(0));
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [63:0] base_val,
                       input bit rnd, input bit hold, output int t0);
    wait_idle();
    a_req = 1'b1; a_we = we; a_addr = addr;
    @(posedge clk); #1;
    t0 = cyc;
    if (!hold) a_req = 1'b0;
    chk("busy_on_accept", 64'(a_busy), 64'(1));
    push_burst(we, addr, t0, base_val, rnd);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int unsigned lb [6];
    int unsigned k, off;
    logic [31:0] ad;
    int n;

    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    #1;
    chk("rst_stb", 64'(a_stb), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));
    chk("rst_last", 64'(a_last), 64'(0));
    chk("rst_rdata", a_rdata, 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // write-back 0xA0..0xA3 to line at 0x40, then wrapped read starting at word 10
    issue(1'b1, 32'h40, 64'hA0, 1'b0, 1'b0, t0);
    issue(1'b0, 32'h50, 64'h0, 1'b0, 1'b0, t0);
    wait_idle();

    // asynchronous reset in the middle of the latency wait
    issue(1'b0, 32'h40, 64'h0, 1'b0, 1'b0, t0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stb", 64'(a_stb), 64'(0));
    chk("async_rst_last", 64'(a_last), 64'(0));
    chk("async_rst_busy", 64'(a_busy), 64'(0));
    chk("async_rst_rdata", a_rdata, 64'(0));
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // requests during WAIT and XFER are dropped
    issue(1'b1, 32'h80, 64'h0, 1'b1, 1'b0, t0);
    a_req = 1'b1; a_addr = 32'h40; a_we = 1'b0;
    @(posedge clk); #1;
    a_req = 1'b0;
    wait_cyc(t0 + A_LAT + 1);
    a_req = 1'b1;
    @(posedge clk); #1;
    a_req = 1'b0;
    wait_cyc(t0 + A_LAT + A_BURST - 1);
    chk("busy_last_beat", 64'(a_busy), 64'(1));
    wait_cyc(t0 + A_LAT + A_BURST);
    chk("busy_drop", 64'(a_busy), 64'(0));
    repeat (8) @(posedge clk);
    #1;

    // held request is re-accepted on the edge after last, busy never drops
    issue(1'b0, 32'h48, 64'h0, 1'b0, 1'b1, t0);
    wait_cyc(t0 + A_LAT + A_BURST);
    chk("busy_b2b", 64'(a_busy), 64'(1));
    push_burst(1'b0, 32'h48, t0 + A_LAT + A_BURST, 64'h0, 1'b0);
    a_req = 1'b0;
    wait_idle();

    // reset after two write beats: remaining words keep old contents
    issue(1'b1, 32'h40, 64'hB0, 1'b0, 1'b0, t0);
    wait_cyc(t0 + A_LAT + 2);
    pulse_reset();
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, 32'h40, 64'h0, 1'b0, 1'b0, t0);
    wait_idle();

    // randomised traffic over a few lines, with address aliasing above depth
    for (int i = 0; i < 6; i++) begin
      lb[i] = ($urandom % 1024) * A_BURST;
      ad = 32'(lb[i] * 8) | ($urandom << 15);
      issue(1'b1, ad, 64'h0, 1'b1, 1'b0, t0);
    end
    for (int i = 0; i < 40; i++) begin
      k   = $urandom % 6;
      off = $urandom % A_BURST;
      ad  = 32'((lb[k] + off) * 8 + $urandom_range(0, 7)) | ($urandom << 15);
      issue(1'($urandom % 2), ad, 64'h0, 1'b1, 1'b0, t0);
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    wait_idle();

    // 32-bit / 8-beat / latency-1 instance: write words 0..7 then read from word 7
    b_we = 1'b1; b_addr = 32'h0; b_req = 1'b1;
    @(posedge clk); #1;
    b_req = 1'b0;
    chk("b_busy", 64'(b_busy), 64'(1));
    chk("b_stb_early", 64'(b_stb), 64'(0));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      b_wdata = 32'h100 + 32'(i);
      chk("b_wr_stb", 64'(b_stb), 64'(1));
      chk("b_wr_last", 64'(b_last), 64'(i == 7));
    end
    @(posedge clk); #1;
    chk("b_wr_done_stb", 64'(b_stb), 64'(0));
    chk("b_wr_done_busy", 64'(b_busy), 64'(0));
    b_we = 1'b0; b_addr = 32'h1C; b_req = 1'b1;
    @(posedge clk); #1;
    b_req = 1'b0;
    chk("b_rd_stb_early", 64'(b_stb), 64'(0));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("b_rd_stb", 64'(b_stb), 64'(1));
      chk("b_rd_last", 64'(b_last), 64'(i == 7));
      chk("b_rdata", 64'(b_rdata), 64'(32'h100 + 32'((7 + i) % 8)));
    end
    @(posedge clk); #1;
    chk("b_rd_done_stb", 64'(b_stb), 64'(0));

    // single-beat instance: stb and last together for exactly one cycle
    c_we = 1'b1; c_addr = 32'h18; c_req = 1'b1;
    @(posedge clk); #1;
    c_req = 1'b0;
    @(posedge clk); #1;
    chk("c_wait_stb", 64'(c_stb), 64'(0));
    @(posedge clk); #1;
    c_wdata = 64'h1234_5678_9ABC_DEF0;
    chk("c_wr_stb", 64'(c_stb), 64'(1));
    chk("c_wr_last", 64'(c_last), 64'(1));
    @(posedge clk); #1;
    chk("c_wr_done", 64'(c_stb), 64'(0));
    chk("c_wr_busy", 64'(c_busy), 64'(0));
    c_we = 1'b0; c_req = 1'b1;
    @(posedge clk); #1;
    c_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("c_rd_stb", 64'(c_stb), 64'(1));
    chk("c_rd_last", 64'(c_last), 64'(1));
    chk("c_rdata", c_rdata, 64'h1234_5678_9ABC_DEF0);
    @(posedge clk); #1;
    chk("c_rd_done", 64'(c_stb), 64'(0));

    n = 0;
    while (sb_q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sb_drain", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
